// File: rtl/mem_batch_issuer.sv
// mem_batch_issuer
// Accepts one batch of up to MAX_READS read addresses and MAX_WRITES write
// address/value pairs. It registers the batch and issues it over NPORTS read
// ports and NPORTS write ports. Issuing can take several cycles and follows
// the memory-side ready handshake. batch_done pulses once after the last
// request of the batch has been accepted.
//
// Ports:
//   system1000, system1000_rstn     clock, asynchronous active-low reset
//   batch_valid / batch_ready       batch handshake
//   rd_count, rd_addr               read slot count and addresses (slot 0 in LSBs)
//   wr_count, wr_addr, wr_data      write slot count, addresses, values
//   mem_ready                       memory accepts every presented request
//   prd_valid, prd_addr             per-port read requests (port 0 in LSBs)
//   pwr_valid, pwr_addr, pwr_data   per-port write requests
//   batch_done                      one-cycle completion pulse
module mem_batch_issuer #(
    parameter int unsigned ADDR_W     = 30,
    parameter int unsigned DATA_W     = 63,
    parameter int unsigned MAX_READS  = 4,
    parameter int unsigned MAX_WRITES = 4,
    parameter int unsigned NPORTS     = 2,
    parameter int unsigned RC_W       = $clog2(MAX_READS + 1),
    parameter int unsigned WC_W       = $clog2(MAX_WRITES + 1)
) (
    input  logic                       system1000,
    input  logic                       system1000_rstn,
    input  logic                       batch_valid,
    output logic                       batch_ready,
    input  logic [RC_W-1:0]            rd_count,
    input  logic [MAX_READS*ADDR_W-1:0]  rd_addr,
    input  logic [WC_W-1:0]            wr_count,
    input  logic [MAX_WRITES*ADDR_W-1:0] wr_addr,
    input  logic [MAX_WRITES*DATA_W-1:0] wr_data,
    input  logic                       mem_ready,
    output logic [NPORTS-1:0]          prd_valid,
    output logic [NPORTS*ADDR_W-1:0]   prd_addr,
    output logic [NPORTS-1:0]          pwr_valid,
    output logic [NPORTS*ADDR_W-1:0]   pwr_addr,
    output logic [NPORTS*DATA_W-1:0]   pwr_data,
    output logic                       batch_done
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    localparam logic [RC_W-1:0] MAX_RD = RC_W'(MAX_READS);
    localparam logic [WC_W-1:0] MAX_WR = WC_W'(MAX_WRITES);

    state_t                        state, state_nx;
    logic [MAX_READS*ADDR_W-1:0]   rd_addr_q;
    logic [MAX_WRITES*ADDR_W-1:0]  wr_addr_q;
    logic [MAX_WRITES*DATA_W-1:0]  wr_data_q;
    logic [RC_W-1:0]               rd_rem, ri;
    logic [WC_W-1:0]               wr_rem, wi;
    logic [31:0]                   n_rd, n_wr;
    logic                          accept, xfer;

    assign batch_ready = (state == IDLE);
    assign batch_done  = (state == DONE);
    assign accept      = batch_valid && batch_ready;
    assign xfer        = (state == ISSUE) && mem_ready;

    // Requests presented this cycle per channel: min(NPORTS, remaining).
    always_comb begin
        n_rd = (32'(rd_rem) < NPORTS) ? 32'(rd_rem) : NPORTS;
        n_wr = (32'(wr_rem) < NPORTS) ? 32'(wr_rem) : NPORTS;
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (accept) state_nx = ISSUE;
            ISSUE: begin
                // An empty batch leaves without waiting for mem_ready.
                if (rd_rem == '0 && wr_rem == '0) begin
                    state_nx = DONE;
                end else if (mem_ready && 32'(rd_rem) <= NPORTS &&
                             32'(wr_rem) <= NPORTS) begin
                    state_nx = DONE;
                end
            end
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_rem    <= '0;
            wr_rem    <= '0;
            ri        <= '0;
            wi        <= '0;
        end else if (accept) begin
            rd_addr_q <= rd_addr;
            wr_addr_q <= wr_addr;
            wr_data_q <= wr_data;
            rd_rem    <= (rd_count > MAX_RD) ? MAX_RD : rd_count;
            wr_rem    <= (wr_count > MAX_WR) ? MAX_WR : wr_count;
            ri        <= '0;
            wi        <= '0;
        end else if (xfer) begin
            rd_rem <= rd_rem - RC_W'(n_rd);
            ri     <= ri + RC_W'(n_rd);
            wr_rem <= wr_rem - WC_W'(n_wr);
            wi     <= wi + WC_W'(n_wr);
        end
    end

    // Port p carries slot index+p; since p < remaining, the slot is always
    // inside the latched batch.
    always_comb begin
        prd_valid = '0;
        prd_addr  = '0;
        pwr_valid = '0;
        pwr_addr  = '0;
        pwr_data  = '0;
        if (state == ISSUE) begin
            for (int unsigned p = 0; p < NPORTS; p++) begin
                if (p < n_rd) begin
                    prd_valid[p] = 1'b1;
                    prd_addr[p*ADDR_W +: ADDR_W] =
                        rd_addr_q[(32'(ri) + p)*ADDR_W +: ADDR_W];
                end
                if (p < n_wr) begin
                    pwr_valid[p] = 1'b1;
                    pwr_addr[p*ADDR_W +: ADDR_W] =
                        wr_addr_q[(32'(wi) + p)*ADDR_W +: ADDR_W];
                    pwr_data[p*DATA_W +: DATA_W] =
                        wr_data_q[(32'(wi) + p)*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_batch_issuer.sv
// tb_mem_batch_issuer
// Self-checking bench for mem_batch_issuer at default parameters. A queue
// model of pending read/write slots predicts every port output each cycle.
module tb_mem_batch_issuer;

    localparam int unsigned ADDR_W = 30;
    localparam int unsigned DATA_W = 63;
    localparam int unsigned MAXR   = 4;
    localparam int unsigned MAXW   = 4;
    localparam int unsigned NP     = 2;
    localparam int unsigned RC_W   = 3;
    localparam int unsigned WC_W   = 3;

    logic                    clk = 1'b0;
    logic                    rstn = 1'b0;
    logic                    batch_valid = 1'b0;
    logic                    batch_ready;
    logic [RC_W-1:0]         rd_count = '0;
    logic [MAXR*ADDR_W-1:0]  rd_addr = '0;
    logic [WC_W-1:0]         wr_count = '0;
    logic [MAXW*ADDR_W-1:0]  wr_addr = '0;
    logic [MAXW*DATA_W-1:0]  wr_data = '0;
    logic                    mem_ready = 1'b0;
    logic [NP-1:0]           prd_valid, pwr_valid;
    logic [NP*ADDR_W-1:0]    prd_addr, pwr_addr;
    logic [NP*DATA_W-1:0]    pwr_data;
    logic                    batch_done;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    mem_batch_issuer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_READS(MAXR),
        .MAX_WRITES(MAXW), .NPORTS(NP)
    ) dut (
        .system1000(clk), .system1000_rstn(rstn),
        .batch_valid(batch_valid), .batch_ready(batch_ready),
        .rd_count(rd_count), .rd_addr(rd_addr),
        .wr_count(wr_count), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_ready(mem_ready),
        .prd_valid(prd_valid), .prd_addr(prd_addr),
        .pwr_valid(pwr_valid), .pwr_addr(pwr_addr), .pwr_data(pwr_data),
        .batch_done(batch_done)
    );

    task automatic scramble_inputs();
        rd_addr = {$urandom(), $urandom(), $urandom(), $urandom()};
        wr_addr = {$urandom(), $urandom(), $urandom(), $urandom()};
        wr_data = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()};
        rd_count = RC_W'($urandom_range(0, 7));
        wr_count = WC_W'($urandom_range(0, 7));
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (prd_valid !== '0 || pwr_valid !== '0 || batch_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_valids: got rv=%b wv=%b done=%b want 0/0/0",
                     prd_valid, pwr_valid, batch_done);
        end
        checks++;
        if (prd_addr !== '0 || pwr_addr !== '0 || pwr_data !== '0) begin
            errors++;
            $display("FAIL reset_data: got ra=%h wa=%h wd=%h want 0",
                     prd_addr, pwr_addr, pwr_data);
        end
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (batch_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", batch_ready);
        end
    endtask

    // stall_mode: 0 = always ready, 1 = first 3 issue cycles stalled,
    // 2 = random mem_ready. rnd selects random vs. fixed slot contents
    // (reads 0x10+i, writes 0x20+i carrying 5+i).
    task automatic test_batch(input string name, input int unsigned rc,
                              input int unsigned wc, input bit rnd,
                              input int unsigned stall_mode);
        logic [ADDR_W-1:0]    rq[$];
        logic [ADDR_W-1:0]    wq[$];
        logic [DATA_W-1:0]    dq[$];
        logic [ADDR_W-1:0]    a;
        logic [DATA_W-1:0]    d;
        logic [NP-1:0]        e_rv, e_wv;
        logic [NP*ADDR_W-1:0] e_ra, e_wa;
        logic [NP*DATA_W-1:0] e_wd;
        int unsigned          cyc;
        bit                   mr;
        checks++;
        if (batch_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before: got %b want 1", name, batch_ready);
        end
        for (int unsigned i = 0; i < MAXR; i++) begin
            a = rnd ? ADDR_W'($urandom()) : ADDR_W'(32'h10 + i);
            rd_addr[i*ADDR_W +: ADDR_W] = a;
            if (i < rc) rq.push_back(a);
        end
        for (int unsigned i = 0; i < MAXW; i++) begin
            a = rnd ? ADDR_W'($urandom()) : ADDR_W'(32'h20 + i);
            d = rnd ? DATA_W'({$urandom(), $urandom()}) : DATA_W'(5 + i);
            wr_addr[i*ADDR_W +: ADDR_W] = a;
            wr_data[i*DATA_W +: DATA_W] = d;
            if (i < wc) begin
                wq.push_back(a);
                dq.push_back(d);
            end
        end
        rd_count    = RC_W'(rc);
        wr_count    = WC_W'(wc);
        batch_valid = 1'b1;
        mem_ready   = 1'b0;
        @(negedge clk);
        batch_valid = 1'b0;
        scramble_inputs();
        cyc = 0;
        do begin
            e_rv = '0; e_ra = '0; e_wv = '0; e_wa = '0; e_wd = '0;
            for (int unsigned p = 0; p < NP; p++) begin
                if (p < rq.size()) begin
                    e_rv[p] = 1'b1;
                    e_ra[p*ADDR_W +: ADDR_W] = rq[p];
                end
                if (p < wq.size()) begin
                    e_wv[p] = 1'b1;
                    e_wa[p*ADDR_W +: ADDR_W] = wq[p];
                    e_wd[p*DATA_W +: DATA_W] = dq[p];
                end
            end
            checks++;
            if (prd_valid !== e_rv || prd_addr !== e_ra) begin
                errors++;
                $display("FAIL %s rd_port c%0d: got v=%b a=%h want v=%b a=%h",
                         name, cyc, prd_valid, prd_addr, e_rv, e_ra);
            end
            checks++;
            if (pwr_valid !== e_wv || pwr_addr !== e_wa || pwr_data !== e_wd) begin
                errors++;
                $display("FAIL %s wr_port c%0d: got v=%b a=%h d=%h want v=%b a=%h d=%h",
                         name, cyc, pwr_valid, pwr_addr, pwr_data, e_wv, e_wa, e_wd);
            end
            checks++;
            if (batch_ready !== 1'b0 || batch_done !== 1'b0) begin
                errors++;
                $display("FAIL %s issue_flags c%0d: got ready=%b done=%b want 0/0",
                         name, cyc, batch_ready, batch_done);
            end
            case (stall_mode)
                0: mr = 1'b1;
                1: mr = (cyc >= 3);
                default: mr = (cyc > 40) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            mem_ready = mr;
            if (mr) begin
                for (int unsigned p = 0; p < NP; p++) begin
                    if (rq.size() > 0) void'(rq.pop_front());
                    if (wq.size() > 0) begin
                        void'(wq.pop_front());
                        void'(dq.pop_front());
                    end
                end
            end
            @(negedge clk);
            cyc++;
        end while ((rq.size() > 0 || wq.size() > 0) && cyc < 100);
        checks++;
        if (cyc >= 100) begin
            errors++;
            $display("FAIL %s timeout: got %0d cycles want <100", name, cyc);
        end
        mem_ready = 1'b0;
        checks++;
        if (batch_done !== 1'b1 || prd_valid !== '0 || pwr_valid !== '0 ||
            batch_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s done_cycle: got done=%b rv=%b wv=%b ready=%b want 1/0/0/0",
                     name, batch_done, prd_valid, pwr_valid, batch_ready);
        end
        @(negedge clk);
        checks++;
        if (batch_done !== 1'b0 || batch_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s after_done: got done=%b ready=%b want 0/1",
                     name, batch_done, batch_ready);
        end
    endtask

    task automatic test_mid_reset();
        for (int unsigned i = 0; i < MAXR; i++)
            rd_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom());
        rd_count    = RC_W'(4);
        wr_count    = '0;
        batch_valid = 1'b1;
        mem_ready   = 1'b1;
        @(negedge clk);
        batch_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++;
        if (prd_valid !== '0 || pwr_valid !== '0 || batch_done !== 1'b0 ||
            prd_addr !== '0 || pwr_addr !== '0 || pwr_data !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got rv=%b wv=%b done=%b ra=%h want all 0",
                     prd_valid, pwr_valid, batch_done, prd_addr);
        end
        mem_ready = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int unsigned c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (batch_done !== 1'b0 || batch_ready !== 1'b1) begin
                errors++;
                $display("FAIL midreset_nodone c%0d: got done=%b ready=%b want 0/1",
                         c, batch_done, batch_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_batch("directed_r3w1", 3, 1, 1'b0, 0);
        test_batch("stall_r3w1", 3, 1, 1'b0, 1);
        test_batch("zero_batch", 0, 0, 1'b1, 1);
        // rd_count=7 is clamped to four issued reads
        test_batch("clamp_r7", 7, 0, 1'b1, 0);
        test_batch("w4_only", 0, 4, 1'b0, 0);
        test_mid_reset();
        test_batch("after_reset_r4", 4, 0, 1'b1, 0);
        for (int unsigned k = 0; k < 20; k++) begin
            test_batch("random", $urandom_range(0, 7), $urandom_range(0, 7),
                       1'b1, 2);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_batch_issuer.md
Name: mem_batch_issuer

Overview:
Parametrised successor to the machine's combinational request initiator. It accepts one batch of up to MAX_READS read addresses and MAX_WRITES write address/value pairs. It registers the batch and issues it over NPORTS read ports and NPORTS write ports, several cycles if needed, under a memory-side ready handshake. It sits between the machine's step logic and the memory arbiter and signals batch completion.

Parameters:
ADDR_W, 30, address width
DATA_W, 63, write value width
MAX_READS, 4, read slots per batch
MAX_WRITES, 4, write slots per batch
NPORTS, 2, memory ports per direction; each of MAX_READS and MAX_WRITES must be >= 1 and NPORTS >= 1
RC_W, $clog2(MAX_READS+1), read count width
WC_W, $clog2(MAX_WRITES+1), write count width

Ports:
system1000  in  1  clock
system1000_rstn  in  1  asynchronous active-low reset
batch_valid  in  1  batch offered
batch_ready  out  1  issuer can accept a batch
rd_count  in  RC_W  number of valid read slots
rd_addr  in  MAX_READS*ADDR_W  read addresses, slot 0 in LSBs
wr_count  in  WC_W  number of valid write slots
wr_addr  in  MAX_WRITES*ADDR_W  write addresses, slot 0 in LSBs
wr_data  in  MAX_WRITES*DATA_W  write values, slot 0 in LSBs
mem_ready  in  1  memory accepts all presented port requests this cycle
prd_valid  out  NPORTS  per-port read request valid
prd_addr  out  NPORTS*ADDR_W  per-port read address, port 0 in LSBs
pwr_valid  out  NPORTS  per-port write request valid
pwr_addr  out  NPORTS*ADDR_W  per-port write address
pwr_data  out  NPORTS*DATA_W  per-port write value
batch_done  out  1  one-cycle pulse when the last request of a batch is accepted

Behaviour:
- Reset values: state IDLE; batch_ready=1 after reset release; prd_valid, pwr_valid and batch_done are 0; all address/data outputs and internal registers are 0.
- FSM states: IDLE, ISSUE, DONE.
- IDLE: batch_ready=1. On batch_valid&batch_ready the block latches all slots. It latches rd_rem = min(rd_count, MAX_READS) and wr_rem = min(wr_count, MAX_WRITES); a count above the maximum is clamped. It clears the read index ri and write index wi, then goes to ISSUE next cycle.
- ISSUE: batch_ready=0.
  - Read ports: port p (p < min(NPORTS, rd_rem)) has prd_valid[p]=1 and prd_addr[p]=slot ri+p. Write ports follow the same rule with wr_rem, wi and both the address and value of the slot.
  - Unused ports drive valid=0 and address/data=0.
  - Port outputs are decoded from registered state only, with no combinational path from the batch inputs.
  - When mem_ready=1, every presented request is accepted. ri and rd_rem advance by the number of reads issued; wi and wr_rem advance by the number of writes issued.
  - When mem_ready=0, all port outputs hold stable.
  - Reads and writes progress independently. The channel that finishes first drives zero valids while the other continues.
  - The transfer after which rd_rem=0 and wr_rem=0 moves the FSM to DONE.
- Zero batch: if rd_count=0 and wr_count=0, ISSUE lasts one cycle with no valids, and mem_ready is ignored. The FSM then goes to DONE.
- DONE: batch_done=1 for exactly one cycle and all valids are 0. Next state is IDLE.
- Throughput and latency: accept to first request is 1 cycle. Issue cycles = max(ceil(R/NPORTS), ceil(W/NPORTS)) accepted transfers, minimum 1. The minimum spacing between back-to-back batches is issue cycles + 2.
- Ordering: lower slot index always goes to a lower-numbered port, or to an earlier cycle. Read/write address conflicts within a cycle are resolved by the memory, not by this block.
- Asynchronous reset mid-batch discards the batch and returns to the reset values immediately. No batch_done is produced for the discarded batch.

Test Plan:
- Default parameters. Accept R=3 (addresses 0x10, 0x11, 0x12) and W=1 (0x20 with value 5), mem_ready=1.
  - Cycle 1: prd_valid=2'b11 with 0x10/0x11, and pwr_valid=2'b01 with 0x20/5.
  - Cycle 2: prd_valid=2'b01 with 0x12, and pwr_valid=0.
  - Cycle 3: batch_done=1.
  - Cycle 4: batch_ready=1.
- Same batch with mem_ready=0 for 3 cycles in ISSUE: outputs are identical and stable during the stall. The sequence resumes exactly as above once mem_ready returns to 1.
- Zero batch (R=0, W=0): no valids at any point, and batch_done fires 2 cycles after accept.
- Clamping: rd_count=7 with MAX_READS=4 and 4 distinct addresses. Exactly 4 reads are issued over 2 cycles, and no valid is raised beyond slot 3.
- W=4, R=0: two cycles with pwr_valid=2'b11 carrying slots 0/1 then 2/3, and prd_valid=0 throughout.
- Assert system1000_rstn=0 during cycle 2 of a 4-read batch. Outputs immediately match the reset values, with no batch_done. After release, a new batch issues from slot 0.
